// File: rtl/apb_slave_regfile_if.sv
// APB4 bus bundle between a requester (master) and the register-file completer (slave).
// Signal names follow the APB4 protocol names so waveforms line up with the bus spec.
interface apb_slave_regfile_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB4 completer with a byte-strobed register file, programmable wait states
// and PSLVERR generation. All bus outputs come straight from flops.
//
// Optional build macro: APB_SLV_STATUS_EN
//   When defined, the last register becomes a read-only status word
//   {xfer_cnt[15:0], err_cnt[15:0]} counting completed and errored transfers.
//   When undefined, the last register is an ordinary read/write register.
module apb_slave_regfile #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_slave_regfile_if.slave  apb
);

    localparam int                    STRB_W     = DATA_WIDTH / 8;
    localparam int                    IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);
    localparam logic [3:0]            WAIT_LOAD  = 4'(WAIT_STATES);
    localparam bit                    ZERO_WAIT  = (WAIT_STATES == 0);
`ifdef APB_SLV_STATUS_EN
    localparam logic [IDX_W-1:0]      STATUS_IDX = IDX_W'(NUM_REGS - 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Error rule for one transfer: misaligned, out of range, read with
    // strobes, or (with the status register present) a write to it.
    function automatic logic xfer_error(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  wr,
        input logic [STRB_W-1:0]     strb
    );
        logic                  err;
        logic [ADDR_WIDTH-1:0] word;
        word = addr >> 2;
        err  = (addr[1:0] != 2'b00) || (word >= NUM_REGS_A) ||
               (!wr && (strb != {STRB_W{1'b0}}));
`ifdef APB_SLV_STATUS_EN
        err  = err || (wr && (word == ADDR_WIDTH'(NUM_REGS - 1)));
`endif
        return err;
    endfunction

    // FSM state
    state_e                 state_q, state_d;

    // Latched setup-phase values and wait counter
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   write_q, write_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]      strb_q, strb_d;

    // Registered bus outputs
    logic                   pready_q, pready_d;
    logic [DATA_WIDTH-1:0]  prdata_q, prdata_d;
    logic                   pslverr_q, pslverr_d;

    // Register file
    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];

`ifdef APB_SLV_STATUS_EN
    logic [15:0]            xfer_cnt_q;
    logic [15:0]            err_cnt_q;
`endif

    // Decoded bus events
    logic                   setup_s;
    logic                   wait_s;
    logic                   complete_s;
    logic                   wr_en_s;
    logic [IDX_W-1:0]       wr_idx_s;

    // Transfer being evaluated this cycle: bus values on a setup edge,
    // latched values during the access phase.
    logic [ADDR_WIDTH-1:0]  sel_addr_s;
    logic                   sel_write_s;
    logic [STRB_W-1:0]      sel_strb_s;
    logic                   sel_err_s;
    logic [IDX_W-1:0]       sel_idx_s;
    logic [DATA_WIDTH-1:0]  sel_rdata_s;

    assign setup_s    = apb.PSEL & ~apb.PENABLE;
    assign wait_s     = (state_q == ST_ACCESS) & apb.PSEL & apb.PENABLE & ~pready_q;
    assign complete_s = (state_q == ST_ACCESS) & apb.PSEL & apb.PENABLE &  pready_q;
    assign wr_en_s    = complete_s & write_q & ~pslverr_q;
    assign wr_idx_s   = addr_q[IDX_W+1:2];

    assign apb.PREADY  = pready_q;
    assign apb.PRDATA  = prdata_q;
    assign apb.PSLVERR = pslverr_q;

    // Choose the transfer under evaluation and look up its read data and error.
    always_comb begin
        if (setup_s) begin
            sel_addr_s  = apb.PADDR;
            sel_write_s = apb.PWRITE;
            sel_strb_s  = apb.PSTRB;
        end else begin
            sel_addr_s  = addr_q;
            sel_write_s = write_q;
            sel_strb_s  = strb_q;
        end
        sel_idx_s = sel_addr_s[IDX_W+1:2];
        sel_err_s = xfer_error(sel_addr_s, sel_write_s, sel_strb_s);
`ifdef APB_SLV_STATUS_EN
        if (sel_idx_s == STATUS_IDX) begin
            sel_rdata_s = DATA_WIDTH'({xfer_cnt_q, err_cnt_q});
        end else begin
            sel_rdata_s = regs_q[sel_idx_s];
        end
`else
        sel_rdata_s = regs_q[sel_idx_s];
`endif
    end

    // FSM state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a setup phase is accepted from any state; DONE acts as IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (setup_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (!apb.PENABLE) begin
                    state_d = ST_ACCESS;
                end else if (pready_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: latch setup values, count wait states, raise the response.
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        pready_d  = 1'b0;
        prdata_d  = {DATA_WIDTH{1'b0}};
        pslverr_d = 1'b0;
        if (setup_s) begin
            addr_d  = apb.PADDR;
            write_d = apb.PWRITE;
            wdata_d = apb.PWDATA;
            strb_d  = apb.PSTRB;
            cnt_d   = WAIT_LOAD;
            if (ZERO_WAIT) begin
                pready_d  = 1'b1;
                pslverr_d = sel_err_s;
                prdata_d  = sel_err_s ? {DATA_WIDTH{1'b0}} : sel_rdata_s;
            end else begin
                pready_d  = 1'b0;
            end
        end else if (wait_s) begin
            if (cnt_q <= 4'd1) begin
                cnt_d     = 4'd0;
                pready_d  = 1'b1;
                pslverr_d = sel_err_s;
                prdata_d  = sel_err_s ? {DATA_WIDTH{1'b0}} : sel_rdata_s;
            end else begin
                cnt_d     = cnt_q - 4'd1;
            end
        end else begin
            // Completion, abort or idle: response returns to all-zero.
            cnt_d = cnt_q;
        end
    end

    // Latched transfer fields, wait counter and registered bus outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q     <= 4'd0;
            addr_q    <= {ADDR_WIDTH{1'b0}};
            write_q   <= 1'b0;
            wdata_q   <= {DATA_WIDTH{1'b0}};
            strb_q    <= {STRB_W{1'b0}};
            pready_q  <= 1'b0;
            prdata_q  <= {DATA_WIDTH{1'b0}};
            pslverr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            pready_q  <= pready_d;
            prdata_q  <= prdata_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Register file: commit strobed bytes at the completion edge of a good write.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            regs_q <= '{default: {DATA_WIDTH{1'b0}}};
        end else if (wr_en_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (strb_q[b]) begin
                    regs_q[wr_idx_s][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

`ifdef APB_SLV_STATUS_EN
    // Saturating transfer and error counters, stepped at each completion edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            xfer_cnt_q <= 16'd0;
            err_cnt_q  <= 16'd0;
        end else if (complete_s) begin
            if (xfer_cnt_q != 16'hFFFF) begin
                xfer_cnt_q <= xfer_cnt_q + 16'd1;
            end
            if (pslverr_q && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: directed vector table, hand-written
// reset/abort/back-to-back sequences and a randomized phase against a
// word-array reference model. Honours APB_SLV_STATUS_EN when defined.
module tb_apb_slave_regfile;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int WS = 2;
`ifdef APB_SLV_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        bit          b2b;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    logic PCLK;
    logic PRESET;

    apb_slave_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_slave_regfile #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REGS   (NR),
        .WAIT_STATES(WS)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .apb    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] mdl_mem [NR];
    logic [15:0] mdl_xfer;
    logic [15:0] mdl_err;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < NR; i++) mdl_mem[i] = 32'd0;
        mdl_xfer = 16'd0;
        mdl_err  = 16'd0;
    endtask

    // One completed APB transfer applied to the reference model.
    task automatic mdl_access(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                              input logic [3:0] st, output logic [31:0] rd, output bit er);
        int w;
        w  = int'(addr) / 4;
        er = (int'(addr) % 4 != 0) || (w >= NR) || (!wr && st != 4'd0) ||
             (STATUS_EN && wr && w == NR - 1);
        rd = 32'd0;
        if (!er && !wr) begin
            if (STATUS_EN && w == NR - 1) rd = {mdl_xfer, mdl_err};
            else                          rd = mdl_mem[w];
        end
        if (!er && wr) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) mdl_mem[w][8*b +: 8] = wd[8*b +: 8];
        end
        if (mdl_xfer != 16'hFFFF) mdl_xfer = mdl_xfer + 16'd1;
        if (er && mdl_err != 16'hFFFF) mdl_err = mdl_err + 16'd1;
    endtask

    task automatic bus_idle();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = 8'd0;
        bus.PWDATA  = 32'd0;
        bus.PSTRB   = 4'd0;
    endtask

    // Full transfer starting at a negedge; returns at the negedge after completion.
    task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                            input logic [3:0] st, input bit b2b, input string tag,
                            output logic [31:0] rd, output bit er);
        int k;
        bit early_bad;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = addr; bus.PWDATA = wd; bus.PSTRB = st;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        k = 1;
        early_bad = 1'b0;
        while (bus.PREADY !== 1'b1 && k <= 20) begin
            if (bus.PRDATA !== 32'd0 || bus.PSLVERR !== 1'b0) early_bad = 1'b1;
            @(negedge PCLK);
            k++;
        end
        chk({tag, "_ready_cycle"}, 32'(k), 32'(WS + 1));
        chk({tag, "_wait_outputs_zero"}, 32'(early_bad), 32'd0);
        rd = bus.PRDATA;
        er = bus.PSLVERR;
        @(negedge PCLK);
        chk({tag, "_pready_cleared"}, 32'(bus.PREADY), 32'd0);
        if (!b2b) bus_idle();
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [31:0] rd;
        bit er;
        apb_xfer(v.wr, v.addr, v.wdata, v.strb, v.b2b, tag, rd, er);
        chk({tag, "_pslverr"}, 32'(er), 32'(v.exp_err));
        if (!v.wr) chk({tag, "_prdata"}, rd, v.exp_rdata);
    endtask

    // Directed vector with bench constants as expectation; model kept in step.
    task automatic model_and_run(input vec_t v, input string tag);
        logic [31:0] mrd;
        bit mer;
        mdl_access(v.wr, v.addr, v.wdata, v.strb, mrd, mer);
        run_vec(v, tag);
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 8'h08, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 8'h08, 32'h11223344, 4'h5, 1'b0, 32'h0,        1'b0};
        tbl[3] = '{1'b0, 8'h08, 32'h0,        4'h0, 1'b0, 32'hDE22BE44, 1'b0};
        tbl[4] = '{1'b1, 8'h08, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0,        1'b0};
        tbl[5] = '{1'b0, 8'h08, 32'h0,        4'h0, 1'b0, 32'hDE22BE44, 1'b0};
        tbl[6] = '{1'b1, 8'h0A, 32'h12345678, 4'hF, 1'b0, 32'h0,        1'b1};
        tbl[7] = '{1'b0, 8'h80, 32'h0,        4'h0, 1'b0, 32'h0,        1'b1};
        tbl[8] = '{1'b0, 8'h08, 32'h0,        4'h1, 1'b0, 32'h0,        1'b1};
        tbl[9] = '{1'b0, 8'h08, 32'h0,        4'h0, 1'b0, 32'hDE22BE44, 1'b0};

        mdl_reset();
        bus_idle();
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        chk("reset_pready",  32'(bus.PREADY),  32'd0);
        chk("reset_prdata",  bus.PRDATA,       32'd0);
        chk("reset_pslverr", 32'(bus.PSLVERR), 32'd0);
        PRESET = 1'b0;

        // Reset asserted in the 2nd access cycle of a write to 0x08.
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 8'h08; bus.PWDATA = 32'hDEADBEEF; bus.PSTRB = 4'hF;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        chk("rst1_pready_cycle2", 32'(bus.PREADY), 32'd0);
        #2 PRESET = 1'b1;
        #1;
        chk("rst1_pready",  32'(bus.PREADY),  32'd0);
        chk("rst1_prdata",  bus.PRDATA,       32'd0);
        chk("rst1_pslverr", 32'(bus.PSLVERR), 32'd0);
        @(negedge PCLK);
        bus_idle();
        @(negedge PCLK);
        PRESET = 1'b0;
        mdl_reset();
        model_and_run('{1'b0, 8'h08, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0}, "rst1_readback");

        // Directed table.
        for (int i = 0; i < 10; i++) model_and_run(tbl[i], $sformatf("vec%0d", i));

        // Abort: PSEL dropped after one access cycle.
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 8'h10; bus.PWDATA = 32'h5A5A5A5A; bus.PSTRB = 4'hF;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        bus_idle();
        @(negedge PCLK);
        chk("abort_pready", 32'(bus.PREADY), 32'd0);
        @(negedge PCLK);
        chk("abort_pready_late", 32'(bus.PREADY), 32'd0);
        model_and_run('{1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0}, "abort_readback");

        // New setup phase during ACCESS replaces the pending write.
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
        bus.PADDR = 8'h14; bus.PWDATA = 32'h00000077; bus.PSTRB = 4'hF;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        model_and_run('{1'b0, 8'h14, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0}, "resetup_read");

        // Back-to-back writes with no idle cycle.
        model_and_run('{1'b1, 8'h04, 32'h1, 4'hF, 1'b1, 32'h0, 1'b0}, "b2b_w0");
        model_and_run('{1'b1, 8'h0C, 32'h2, 4'hF, 1'b0, 32'h0, 1'b0}, "b2b_w1");
        model_and_run('{1'b0, 8'h04, 32'h0, 4'h0, 1'b1, 32'h1, 1'b0}, "b2b_r0");
        model_and_run('{1'b0, 8'h0C, 32'h0, 4'h0, 1'b0, 32'h2, 1'b0}, "b2b_r1");

        // Randomized transfers checked against the model.
        for (int i = 0; i < 60; i++) begin
            vec_t        v;
            logic [31:0] erd;
            bit          eer;
            int          sel;
            sel = int'($urandom_range(0, 9));
            v.wr = 1'($urandom_range(0, 1));
            case (sel)
                6:       v.addr = 8'h7C;
                7:       v.addr = 8'(($urandom_range(0, 31) * 4) + $urandom_range(1, 3));
                8:       v.addr = 8'(32'h80 + $urandom_range(0, 31) * 4);
                9:       v.addr = 8'($urandom);
                default: v.addr = 8'($urandom_range(0, 31) * 4);
            endcase
            v.wdata = $urandom;
            if (v.wr) v.strb = 4'($urandom);
            else      v.strb = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0;
            v.b2b = (i == 59) ? 1'b0 : 1'($urandom_range(0, 1));
            mdl_access(v.wr, v.addr, v.wdata, v.strb, erd, eer);
            v.exp_rdata = erd;
            v.exp_err   = eer;
            run_vec(v, $sformatf("rnd%0d", i));
        end

        // Reset while a read of a non-zero register is in its ready cycle.
        model_and_run('{1'b1, 8'h08, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1'b0}, "rst2_write");
        begin
            int k;
            bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
            bus.PADDR = 8'h08; bus.PWDATA = 32'h0; bus.PSTRB = 4'h0;
            @(negedge PCLK);
            bus.PENABLE = 1'b1;
            k = 1;
            while (bus.PREADY !== 1'b1 && k <= 20) begin
                @(negedge PCLK);
                k++;
            end
            chk("rst2_ready_cycle", 32'(k), 32'(WS + 1));
            chk("rst2_prdata_before", bus.PRDATA, 32'hCAFEF00D);
            #2 PRESET = 1'b1;
            #1;
            chk("rst2_pready",  32'(bus.PREADY),  32'd0);
            chk("rst2_prdata",  bus.PRDATA,       32'd0);
            chk("rst2_pslverr", 32'(bus.PSLVERR), 32'd0);
            @(negedge PCLK);
            bus_idle();
            @(negedge PCLK);
            PRESET = 1'b0;
            mdl_reset();
        end

`ifdef APB_SLV_STATUS_EN
        // Status register: 3 good transfers, 1 errored, then read counters.
        model_and_run('{1'b1, 8'h00, 32'h1, 4'hF, 1'b0, 32'h0,        1'b0}, "st_w0");
        model_and_run('{1'b1, 8'h04, 32'h2, 4'hF, 1'b0, 32'h0,        1'b0}, "st_w1");
        model_and_run('{1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 32'h1,        1'b0}, "st_r0");
        model_and_run('{1'b1, 8'h0A, 32'h3, 4'hF, 1'b0, 32'h0,        1'b1}, "st_err");
        model_and_run('{1'b0, 8'h7C, 32'h0, 4'h0, 1'b0, 32'h00040001, 1'b0}, "st_read1");
        model_and_run('{1'b1, 8'h7C, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0, 1'b1}, "st_write");
        model_and_run('{1'b0, 8'h7C, 32'h0, 4'h0, 1'b0, 32'h00060002, 1'b0}, "st_read2");
`endif

        model_and_run('{1'b0, 8'h08, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0}, "rst2_readback");

        repeat (2) @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
